// File: rtl/coord_intersect.sv
// coord_intersect: merges two ascending sparse coordinate streams and emits
// value pairs plus their product at every coordinate present in both.
module coord_intersect #(
    parameter int COORD_W = 4,
    parameter int VAL_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [COORD_W-1:0]   a_coord,
    input  logic [VAL_W-1:0]     a_value,
    input  logic                 a_last,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [COORD_W-1:0]   b_coord,
    input  logic [VAL_W-1:0]     b_value,
    input  logic                 b_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [COORD_W-1:0]   out_coord,
    output logic [VAL_W-1:0]     out_a,
    output logic [VAL_W-1:0]     out_b,
    output logic [2*VAL_W-1:0]   out_prod,
    output logic                 done,
    output logic [COORD_W:0]     match_cnt
);
    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t               state_q, state_d;
    logic                 a_fin_q, a_fin_d, b_fin_q, b_fin_d;
    logic                 out_valid_q, out_valid_d;
    logic [COORD_W-1:0]   out_coord_q, out_coord_d;
    logic [VAL_W-1:0]     out_a_q, out_a_d, out_b_q, out_b_d;
    logic [2*VAL_W-1:0]   out_prod_q, out_prod_d;
    logic [COORD_W:0]     cnt_q, cnt_d, match_cnt_q, match_cnt_d;
    logic                 slot_free, load, a_pop, b_pop;
    logic [2*VAL_W-1:0]   prod;

    assign prod = (2*VAL_W)'(a_value) * (2*VAL_W)'(b_value);

    always_comb begin
        slot_free   = !out_valid_q || out_ready;
        load        = 1'b0;
        a_pop       = 1'b0;
        b_pop       = 1'b0;
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        if (state_q == RUN) begin
            // once one side has finished, the other is simply flushed
            if (a_fin_q)
                b_pop = b_valid;
            else if (b_fin_q)
                a_pop = a_valid;
            else if (a_valid && b_valid) begin
                a_pop = (a_coord < b_coord) || (a_coord == b_coord && slot_free);
                b_pop = (a_coord > b_coord) || (a_coord == b_coord && slot_free);
                load  = (a_coord == b_coord) && slot_free;
            end
        end
        a_fin_d     = a_fin_q || (a_pop && a_last);
        b_fin_d     = b_fin_q || (b_pop && b_last);
        cnt_d       = cnt_q + (COORD_W+1)'(load);
        out_valid_d = load || (out_valid_q && !out_ready);
        out_coord_d = load ? a_coord : out_coord_q;
        out_a_d     = load ? a_value : out_a_q;
        out_b_d     = load ? b_value : out_b_q;
        out_prod_d  = load ? prod : out_prod_q;
        case (state_q)
            RUN:     state_d = (a_fin_d && b_fin_d) ? DRAIN : RUN;
            DRAIN:   state_d = slot_free ? DONE : DRAIN;
            default: begin
                state_d     = RUN;
                match_cnt_d = cnt_q;
                cnt_d       = '0;
                a_fin_d     = 1'b0;
                b_fin_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            a_fin_q     <= 1'b0;
            b_fin_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_coord_q <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_prod_q  <= '0;
            cnt_q       <= '0;
            match_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            a_fin_q     <= a_fin_d;
            b_fin_q     <= b_fin_d;
            out_valid_q <= out_valid_d;
            out_coord_q <= out_coord_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_prod_q  <= out_prod_d;
            cnt_q       <= cnt_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    // readies are combinational, so they are masked while reset is held
    assign a_ready   = rst && a_pop;
    assign b_ready   = rst && b_pop;
    assign out_valid = out_valid_q;
    assign out_coord = out_coord_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_prod  = out_prod_q;
    assign done      = (state_q == DONE);
    assign match_cnt = match_cnt_q;
endmodule

// File: tb/tb_coord_intersect.sv
// tb_coord_intersect: directed streams with a queue scoreboard and a separate
// negedge monitor that checks every output handshake and done pulse.
module tb_coord_intersect;
    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, a_ready, a_last, b_valid, b_ready, b_last;
    logic [3:0]  a_coord, b_coord, out_coord;
    logic [7:0]  a_value, b_value, out_a, out_b;
    logic        out_valid, out_ready, done;
    logic [15:0] out_prod;
    logic [4:0]  match_cnt;

    typedef struct {
        int c;
        int a;
        int b;
        int p;
    } exp_t;

    exp_t sb[$];
    int   mc_q[$];
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   a_c[8], a_v[8], b_c[8], b_v[8];
    int   na, nb;

    coord_intersect #(.COORD_W(4), .VAL_W(8)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_coord(a_coord), .a_value(a_value), .a_last(a_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_coord(b_coord), .b_value(b_value), .b_last(b_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_coord(out_coord),
        .out_a(out_a), .out_b(out_b), .out_prod(out_prod),
        .done(done), .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        bit prev_done = 1'b0;
        bit mc_pend = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL out_unexpected got c=%0d a=%0d b=%0d p=%0d want none",
                             out_coord, out_a, out_b, out_prod);
                end else begin
                    e = sb.pop_front();
                    if (int'(out_coord) != e.c || int'(out_a) != e.a || int'(out_b) != e.b || int'(out_prod) != e.p) begin
                        bad++;
                        $display("FAIL out_pair got c=%0d a=%0d b=%0d p=%0d want c=%0d a=%0d b=%0d p=%0d",
                                 out_coord, out_a, out_b, out_prod, e.c, e.a, e.b, e.p);
                    end
                end
            end
            if (mc_pend) begin
                mc_pend = 1'b0;
                total++;
                if (mc_q.size() == 0) begin
                    bad++;
                    $display("FAIL match_cnt_unexpected got=%0d want none", match_cnt);
                end else if (int'(match_cnt) != mc_q[0]) begin
                    bad++;
                    $display("FAIL match_cnt got=%0d want=%0d", match_cnt, mc_q[0]);
                    void'(mc_q.pop_front());
                end else
                    void'(mc_q.pop_front());
            end
            if (done) begin
                done_cnt++;
                mc_pend = 1'b1;
                total++;
                if (prev_done) begin
                    bad++;
                    $display("FAIL done_width got=2+ cycles want=1");
                end
            end
            prev_done = done;
        end
    end

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic set_a(input int n, input int c[8], input int v[8]);
        na = n; a_c = c; a_v = v;
    endtask

    task automatic set_b(input int n, input int c[8], input int v[8]);
        nb = n; b_c = c; b_v = v;
    endtask

    task automatic push(input int c, input int a, input int b, input int p);
        sb.push_back('{c, a, b, p});
    endtask

    // drives both streams until done (or until one cycle after the first output when abort is set)
    task automatic run_op(input int stall, input int sc, input int sp, input bit abort);
        int ai = 0, bi = 0, cyc = 0, lone = 0, seen = 0, base = done_cnt;
        bit fa, fb;
        while (done_cnt == base && cyc < 200) begin
            a_valid = ai < na;
            a_coord = 4'(ai < na ? a_c[ai] : 0);
            a_value = 8'(ai < na ? a_v[ai] : 0);
            a_last  = ai == na - 1;
            b_valid = bi < nb;
            b_coord = 4'(bi < nb ? b_c[bi] : 0);
            b_value = 8'(bi < nb ? b_v[bi] : 0);
            b_last  = bi == nb - 1;
            if (stall > 0 && out_valid) begin
                out_ready = 1'b0;
                stall--;
            end else
                out_ready = 1'b1;
            @(negedge clk);
            if (!out_ready) begin
                chk("stall_coord", out_coord, sc);
                chk("stall_prod", out_prod, sp);
                chk("stall_ready", {a_ready, b_ready}, 0);
            end
            if ((ai < na && bi == nb && !a_ready) || (bi < nb && ai == na && !b_ready)) lone++;
            fa = a_valid && a_ready;
            fb = b_valid && b_ready;
            if (seen > 0 || out_valid) seen++;
            if (abort && seen == 2) break;
            @(posedge clk);
            #1;
            if (fa) ai++;
            if (fb) bi++;
            cyc++;
        end
        if (!abort) begin
            chk("op_done", done_cnt - base, 1);
            chk("flush_ready", lone, 0);
            chk("streams_consumed", (ai == na && bi == nb) ? 1 : 0, 1);
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic idle();
        a_valid = 1'b0;
        b_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        out_ready = 1'b1;
        a_valid = 1'b1; a_coord = 4'd3; a_value = 8'd1; a_last = 1'b1;
        b_valid = 1'b1; b_coord = 4'd3; b_value = 8'd1; b_last = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_match_cnt", match_cnt, 0);
        chk("rst_out_prod", out_prod, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        a_valid = 1'b0;
        b_valid = 1'b0;
        rst = 1'b1;
        idle();

        set_a(4, '{1, 3, 5, 7, 0, 0, 0, 0}, '{10, 20, 30, 40, 0, 0, 0, 0});
        set_b(3, '{3, 4, 7, 0, 0, 0, 0, 0}, '{2, 5, 6, 0, 0, 0, 0, 0});
        push(3, 20, 2, 40); push(7, 40, 6, 240); mc_q.push_back(2);
        run_op(0, 0, 0, 1'b0);
        idle();

        set_a(2, '{0, 2, 0, 0, 0, 0, 0, 0}, '{1, 1, 0, 0, 0, 0, 0, 0});
        set_b(2, '{1, 3, 0, 0, 0, 0, 0, 0}, '{1, 1, 0, 0, 0, 0, 0, 0});
        mc_q.push_back(0);
        run_op(0, 0, 0, 1'b0);
        idle();

        set_a(2, '{4, 6, 0, 0, 0, 0, 0, 0}, '{9, 1, 0, 0, 0, 0, 0, 0});
        set_b(2, '{4, 6, 0, 0, 0, 0, 0, 0}, '{3, 2, 0, 0, 0, 0, 0, 0});
        push(4, 9, 3, 27); push(6, 1, 2, 2); mc_q.push_back(2);
        run_op(3, 4, 27, 1'b0);
        idle();

        set_a(1, '{1, 0, 0, 0, 0, 0, 0, 0}, '{5, 0, 0, 0, 0, 0, 0, 0});
        set_b(4, '{1, 5, 9, 12, 0, 0, 0, 0}, '{7, 1, 1, 1, 0, 0, 0, 0});
        push(1, 5, 7, 35); mc_q.push_back(1);
        run_op(0, 0, 0, 1'b0);
        idle();

        set_a(1, '{2, 0, 0, 0, 0, 0, 0, 0}, '{255, 0, 0, 0, 0, 0, 0, 0});
        set_b(1, '{2, 0, 0, 0, 0, 0, 0, 0}, '{255, 0, 0, 0, 0, 0, 0, 0});
        push(2, 255, 255, 65025); mc_q.push_back(1);
        run_op(0, 0, 0, 1'b0);
        idle();

        set_a(4, '{1, 3, 5, 7, 0, 0, 0, 0}, '{10, 20, 30, 40, 0, 0, 0, 0});
        set_b(3, '{3, 4, 7, 0, 0, 0, 0, 0}, '{2, 5, 6, 0, 0, 0, 0, 0});
        push(3, 20, 2, 40); push(7, 40, 6, 240);
        run_op(0, 0, 0, 1'b1);
        a_valid = 1'b1;
        b_valid = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_done", done, 0);
        chk("arst_match_cnt", match_cnt, 0);
        chk("arst_ready", {a_ready, b_ready}, 0);
        chk("arst_out_coord", out_coord, 0);
        sb.delete();
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        rst = 1'b1;
        idle();
        push(3, 20, 2, 40); push(7, 40, 6, 240); mc_q.push_back(2);
        run_op(0, 0, 0, 1'b0);
        idle();

        chk("sb_left", sb.size(), 0);
        chk("mc_left", mc_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
